load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32 load/store unit: aligns and extends loads, builds store strobes/data,
// and runs a single-outstanding request/ack handshake with an ack timeout.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      cur, nxt;
  logic [31:0] addr_r, wdata_r;
  logic [2:0]  f3_r;
  logic        load_r;
  logic [7:0]  cnt;
  logic        err_r, mis_r;
  logic        legal, aligned_ok, accept, fault, in_access, timeout;
  logic [31:0] shifted, extracted;

  // Handshake: mem_req rises in ACCESS and holds mem_addr/mem_we/mem_wstrb/
  // mem_wdata stable until the cycle mem_ack is sampled high (or timeout).
  always_comb begin
    legal      = 1'b0;
    aligned_ok = 1'b0;
    if (is_load) legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else         legal = (funct3 inside {3'b000, 3'b001, 3'b010});
    case (funct3[1:0])
      2'b00:   aligned_ok = 1'b1;
      2'b01:   aligned_ok = ~addr[0];
      2'b10:   aligned_ok = (addr[1:0] == 2'b00);
      default: aligned_ok = 1'b0;
    endcase
  end

  assign in_access = (cur == ACCESS);
  assign accept    = (cur == IDLE) & start & (is_load | is_store) & legal & aligned_ok;
  assign fault     = (cur == IDLE) & start & (is_load | is_store) & ~(legal & aligned_ok);
  assign timeout   = in_access & ~mem_ack & (cnt == 8'(ACK_TIMEOUT - 1));

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (accept) nxt = ACCESS;
      ACCESS:  if (mem_ack || timeout) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Halfwords are 2-byte aligned, so the byte shift also selects the half.
  always_comb begin
    shifted = mem_rdata >> {addr_r[1:0], 3'b000};
    case (f3_r)
      3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  extracted = {24'd0, shifted[7:0]};
      3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  extracted = {16'd0, shifted[15:0]};
      default: extracted = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur       <= IDLE;
      cnt       <= 8'd0;
      load_data <= 32'd0;
      err_r     <= 1'b0;
      mis_r     <= 1'b0;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      f3_r      <= 3'd0;
      load_r    <= 1'b0;
    end else begin
      cur   <= nxt;
      mis_r <= fault;
      if (accept) begin
        addr_r  <= addr;
        wdata_r <= wdata;
        f3_r    <= funct3;
        load_r  <= is_load;
        cnt     <= 8'd0;
        err_r   <= 1'b0;
      end
      if (in_access && !mem_ack) cnt <= cnt + 8'd1;
      if (in_access && mem_ack && load_r) load_data <= extracted;
      if (timeout) begin
        err_r <= 1'b1;
        if (load_r) load_data <= 32'd0;
      end
    end
  end

  always_comb begin
    mem_wstrb = 4'b0000;
    mem_wdata = wdata_r;
    case (f3_r[1:0])
      2'b00: begin
        mem_wstrb = 4'b0001 << addr_r[1:0];
        mem_wdata = {4{wdata_r[7:0]}};
      end
      2'b01: begin
        mem_wstrb = 4'b0011 << addr_r[1:0];
        mem_wdata = {2{wdata_r[15:0]}};
      end
      default: mem_wstrb = 4'b1111;
    endcase
    if (!(in_access && !load_r)) mem_wstrb = 4'b0000;
  end

  assign mem_req    = in_access;
  assign mem_we     = in_access & ~load_r;
  assign mem_addr   = {addr_r[31:2], 2'b00};
  assign busy       = in_access | accept;
  assign done       = (cur == RESP);
  assign bus_err    = (cur == RESP) & err_r;
  assign misaligned = mis_r;
  assign state      = cur;

endmodule
